// File: rtl/subtractor_serial_16bit.sv
// Bit-serial 16-bit two's complement subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional macro SUB_ERR_EN adds a sticky err output flagging start requests that arrive while busy.
module subtractor_serial_16bit (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        borrow_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] diff,
    output logic        overflow
`ifdef SUB_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state, next;
    logic [15:0] a_q, b_q, res;
    logic [3:0]  cnt;
    logic        br;
    logic        a_bit, b_bit, d_bit, br_nxt, load;

    // Operands are only accepted outside RUN, so a restart during RUN is ignored.
    assign load = (state != S_RUN) && start;

    always_ff @(posedge clk) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  if (start) next = S_RUN;
            S_RUN:   if (cnt == 4'd15) next = S_DONE;
            S_DONE:  next = start ? S_RUN : S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
    end

    always_comb begin
        a_bit  = a_q[cnt];
        b_bit  = b_q[cnt];
        d_bit  = a_bit ^ b_bit ^ br;
        br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res      <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            diff     <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            // done trails the DONE state by one cycle so it lands 17 edges after start.
            done <= (state == S_DONE);
            if (load) begin
                a_q <= a;
                b_q <= b;
                br  <= borrow_in;
                cnt <= '0;
                res <= '0;
            end else if (state == S_RUN) begin
                res <= {d_bit, res[15:1]};
                br  <= br_nxt;
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    diff     <= {d_bit, res[15:1]};
                    overflow <= (a_q[15] != b_q[15]) && (d_bit != a_q[15]);
                end
            end
        end
    end

`ifdef SUB_ERR_EN
    always_ff @(posedge clk) begin
        if (!n_rst)                        err <= 1'b0;
        else if (state == S_RUN && start)  err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_subtractor_serial_16bit.sv
// Directed-vector bench for subtractor_serial_16bit: timing, arithmetic, mid-run disturbances, reset and back-to-back.
module tb_subtractor_serial_16bit;

    logic        clk = 1'b0;
    logic        n_rst, start, borrow_in;
    logic [15:0] a, b;
    logic        busy, done, overflow;
    logic [15:0] diff;
`ifdef SUB_ERR_EN
    logic        err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    subtractor_serial_16bit dut (
        .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
        .busy(busy), .done(done), .diff(diff), .overflow(overflow)
`ifdef SUB_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b1; a = 16'hFFFF; b = 16'h0001; borrow_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 16'h0000 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b diff=%h ovf=%b, want 0 0 0000 0", busy, done, diff, overflow);
        end
`ifdef SUB_ERR_EN
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
`endif
        start = 1'b0; n_rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored: busy=%b want 0", busy); end
    endtask

    // One operation; chg_at disturbs the operands and restart_at re-pulses start at that RUN cycle.
    task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv, input logic bin,
                          input logic [15:0] ed, input logic eo, input int chg_at, input int restart_at);
        int busy_cnt = 0, done_cnt = 0, done_at = -1;
        logic [15:0] d_seen = 16'hxxxx;
        logic        o_seen = 1'bx;
        @(negedge clk);
        a = av; b = bv; borrow_in = bin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin done_at = i; d_seen = diff; o_seen = overflow; end
            end
            if (i == chg_at) begin a = ~av; b = av ^ 16'h5A5A; borrow_in = ~bin; end
            start = (i == restart_at);
        end
        n_cmp++;
        if (busy_cnt != 16) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want 16", name, busy_cnt); end
        n_cmp++;
        if (done_at != 17) begin n_bad++; $display("FAIL %s done_edge: got k+%0d want k+17", name, done_at); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL %s done_width: got %0d want 1", name, done_cnt); end
        n_cmp++;
        if (d_seen !== ed) begin n_bad++; $display("FAIL %s diff: got %h want %h", name, d_seen, ed); end
        n_cmp++;
        if (o_seen !== eo) begin n_bad++; $display("FAIL %s overflow: got %b want %b", name, o_seen, eo); end
    endtask

    task automatic test_restart_err();
        run_op("restart", 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, -1, 5);
`ifdef SUB_ERR_EN
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err); end
        run_op("err_sticky", 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, -1, -1);
        n_cmp++;
        if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
`endif
    endtask

    task automatic test_reset_mid_run();
        int done_cnt = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        n_cmp++;
        if (busy !== 1'b0 || diff !== 16'h0000 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_run_reset: busy=%b diff=%h ovf=%b want 0 0000 0", busy, diff, overflow);
        end
`ifdef SUB_ERR_EN
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", err); end
`endif
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0) begin n_bad++; $display("FAIL aborted_op_activity: got %0d cycles want 0", done_cnt); end
        run_op("after_reset", 16'h00FF, 16'h0100, 1'b0, 16'hFFFF, 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0, done_cnt = 0, done1 = -1, done2 = -1;
        logic busy17 = 1'b0;
        logic [15:0] d1 = 16'hxxxx;
        @(negedge clk);
        a = 16'h0003; b = 16'h0005; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (i == 17) busy17 = busy;
            if (done) begin
                done_cnt++;
                if (done1 < 0) begin done1 = i; d1 = diff; end
                else if (done2 < 0) done2 = i;
            end
            // Held high across the whole DONE cycle with the new operands.
            if (i == 16) begin a = 16'h1234; b = 16'h0234; start = 1'b1; end
            else start = 1'b0;
        end
        n_cmp++;
        if (d1 !== 16'hFFFE) begin n_bad++; $display("FAIL b2b_first_diff: got %h want fffe", d1); end
        n_cmp++;
        if (busy17 !== 1'b1) begin n_bad++; $display("FAIL b2b_immediate_run: busy=%b want 1", busy17); end
        n_cmp++;
        if (done1 != 17 || done2 != 34) begin
            n_bad++; $display("FAIL b2b_done_edges: got %0d,%0d want 17,34", done1, done2);
        end
        n_cmp++;
        if (done_cnt != 2 || busy_cnt != 32) begin
            n_bad++; $display("FAIL b2b_counts: done=%0d busy=%0d want 2 32", done_cnt, busy_cnt);
        end
        n_cmp++;
        if (diff !== 16'h1000 || overflow !== 1'b0) begin
            n_bad++; $display("FAIL b2b_second_diff: got %h/%b want 1000/0", diff, overflow);
        end
    endtask

    initial begin
        test_reset();
        run_op("basic",       16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, -1, -1);
        run_op("ovf_neg_pos", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, -1, -1);
        run_op("ovf_pos_neg", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, -1, -1);
        run_op("borrow_wrap", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, -1, -1);
        run_op("mid_change",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0,  3, -1);
        run_op("borrow_ovf",  16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b1, -1, -1);
        test_back_to_back();
        test_restart_err();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/subtractor_serial_16bit.md
SUBTRACTOR_SERIAL_16BIT -- requirements
Module: subtractor_serial_16bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and n_rst.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- n_rst  input  1  synchronous active-low reset
- start  input  1  request to begin a subtraction; sampled on the rising edge of clk
- a  input  16  minuend, two's complement
- b  input  16  subtrahend, two's complement
- borrow_in  input  1  borrow into bit 0
- busy  output  1  high while the block is computing
- done  output  1  one-cycle pulse when the result is valid
- diff  output  16  result a - b - borrow_in, modulo 2^16
- overflow  output  1  signed-overflow flag for diff
- err  output  1  sticky protocol-error flag; present only when SUB_ERR_EN is defined

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-004 IDLE -> RUN when start=1: capture a, b and borrow_in into internal registers, clear the bit counter to 0, and preset the running borrow to borrow_in.
REQ-005 RUN SHALL process one bit per cycle, LSB first:
- d_i = a_i ^ b_i ^ br
- br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
- d_i is shifted into the result register.
REQ-006 RUN SHALL last exactly 16 cycles; the block moves RUN -> DONE on the edge where the counter equals 15.
REQ-007 a, b and borrow_in changes during RUN SHALL have no effect; only the captured values are used.
REQ-008 start=1 while in RUN SHALL be ignored.
REQ-009 In DONE, done=1 for exactly one cycle:
- start=1 in DONE -> RUN with new operands captured (back-to-back operation).
- otherwise DONE -> IDLE.
REQ-010 Latency: if start is sampled at edge k, done SHALL be high between edges k+17 and k+18.
REQ-011 busy SHALL be 1 exactly while in RUN.
REQ-012 diff and overflow SHALL update only on entry to DONE, and hold that value until the next entry to DONE or until reset.
REQ-013 overflow SHALL equal (a[15] != b[15]) && (diff[15] != a[15]), evaluated on the captured operands.
REQ-014 The result SHALL wrap modulo 2^16; no output reports the final borrow.
REQ-015 start=1 in the same cycle as n_rst=0 SHALL be ignored (reset wins).

Reset
REQ-016 With n_rst=0 at a rising edge of clk, the block SHALL go to IDLE and force busy=0, done=0, diff=16'h0000, overflow=0, err=0, counter=0 and all captured operands to 0.
REQ-017 Reset during RUN or DONE SHALL abort the operation; done SHALL NOT pulse for the aborted operation.
REQ-018 Reset SHALL have no asynchronous effect.

Configuration
REQ-019 Macro SUB_ERR_EN controls the err feature.
- Defined: the err port exists. err is set to 1 on any edge where start=1 while in RUN, and stays 1 until reset. The ignored start is still ignored.
- Not defined: the err port and its logic are absent.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-020 a=16'h0005, b=16'h0003, borrow_in=0, start pulsed at edge k -> busy high for 16 cycles, done high between edges k+17 and k+18, diff=16'h0002, overflow=0.
REQ-021 a=16'h8000, b=16'h0001, borrow_in=0 -> diff=16'h7FFF, overflow=1. Then a=16'h7FFF, b=16'hFFFF -> diff=16'h8000, overflow=1.
REQ-022 a=16'h0000, b=16'h0000, borrow_in=1 -> diff=16'hFFFF, overflow=0. Change a and b mid-RUN -> result unchanged.
REQ-023 start re-asserted at RUN cycle 5 -> completion timing and diff unchanged. With SUB_ERR_EN defined, err=1 and stays 1 until n_rst=0.
REQ-024 n_rst=0 at RUN cycle 8 -> next cycle: busy=0, diff=16'h0000, overflow=0, no done pulse. A following start completes normally.
REQ-025 start held high through DONE with new operands 16'h1234 - 16'h0234 -> RUN begins immediately, done one cycle wide per operation, diff=16'h1000.
